// File: rtl/fifo_uart_tx_if.sv
`default_nettype none
// ============================================================================
// Module   : fifo_uart_tx_if
// Purpose  : FIFO read-side handshake between the sample FIFO and the UART
//            transmitter.
// Signals  : fifo_empty   - FIFO empty flag (FIFO -> transmitter)
//            fifo_data    - FIFO head byte, valid one cycle after fifo_empty
//                           falls (FIFO -> transmitter)
//            fifo_read_en - one-cycle pop pulse (transmitter -> FIFO); the
//                           FIFO advances its read pointer on its falling edge
// Modports : master - FIFO side (produces data)
//            slave  - transmitter side (consumes data)
// Revision : 1.0 - initial release
// ============================================================================
interface fifo_uart_tx_if;
    logic       fifo_empty;
    logic [7:0] fifo_data;
    logic       fifo_read_en;

    modport master (
        output fifo_empty,
        output fifo_data,
        input  fifo_read_en
    );

    modport slave (
        input  fifo_empty,
        input  fifo_data,
        output fifo_read_en
    );
endinterface
`default_nettype wire

// File: rtl/fifo_uart_tx.sv
`default_nettype none
// ============================================================================
// Module   : fifo_uart_tx
// Purpose  : Drains the sample FIFO and sends each byte as an LSB-first UART
//            frame (8N1, or 8E1 when FIFO_UART_TX_PARITY_EN is defined).
// Params   : CLKS_PER_BIT - sys_clock cycles per UART bit (2..65535)
// Ports    : sys_clock - system clock, rising edge
//            reset     - synchronous active-high reset
//            tx_en     - start gate; a running frame always completes
//            fifo      - FIFO read handshake (slave modport)
//            tx        - registered serial line, idles high
//            busy      - registered, high from WAIT through end of STOP
// Macro    : FIFO_UART_TX_PARITY_EN - adds an even-parity bit after data
// Revision : 1.0 - initial release
// ============================================================================
module fifo_uart_tx #(
    parameter int CLKS_PER_BIT = 868
) (
    input  wire logic     sys_clock,
    input  wire logic     reset,
    input  wire logic     tx_en,
    fifo_uart_tx_if.slave fifo,
    output logic          tx,
    output logic          busy
);

    localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_WAIT   = 3'd1,
        S_START  = 3'd2,
        S_DATA   = 3'd3,
`ifdef FIFO_UART_TX_PARITY_EN
        S_PARITY = 3'd4,
`endif
        S_STOP   = 3'd5
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  shift_q, shift_d;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic [15:0] baud_cnt_q, baud_cnt_d;
    logic        tx_q, tx_d;
    logic        rd_q, rd_d;
    logic        busy_q, busy_d;
    logic        baud_done;
`ifdef FIFO_UART_TX_PARITY_EN
    logic        parity_q, parity_d;
`endif

    assign baud_done = (baud_cnt_q == BAUD_LAST);

    always_ff @(posedge sys_clock) begin
        if (reset) begin
            state_q    <= S_IDLE;
            shift_q    <= 8'h00;
            bit_cnt_q  <= 3'd0;
            baud_cnt_q <= 16'd0;
            tx_q       <= 1'b1;
            rd_q       <= 1'b0;
            busy_q     <= 1'b0;
`ifdef FIFO_UART_TX_PARITY_EN
            parity_q   <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            bit_cnt_q  <= bit_cnt_d;
            baud_cnt_q <= baud_cnt_d;
            tx_q       <= tx_d;
            rd_q       <= rd_d;
            busy_q     <= busy_d;
`ifdef FIFO_UART_TX_PARITY_EN
            parity_q   <= parity_d;
`endif
        end
    end

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        bit_cnt_d  = bit_cnt_q;
        baud_cnt_d = baud_cnt_q;
        tx_d       = tx_q;
        rd_d       = 1'b0;          // pop pulse always ends after one cycle
        busy_d     = busy_q;
`ifdef FIFO_UART_TX_PARITY_EN
        parity_d   = parity_q;
`endif

        case (state_q)
            S_IDLE: begin
                tx_d   = 1'b1;
                busy_d = 1'b0;
                // The empty flag is only looked at here, which is at least
                // two cycles after any earlier pop, so it is never stale.
                if (tx_en && !fifo.fifo_empty) begin
                    state_d = S_WAIT;
                    busy_d  = 1'b1;
                end
            end

            S_WAIT: begin
                // fifo_data is valid now (one cycle after empty fell).
                state_d    = S_START;
                shift_d    = fifo.fifo_data;
                rd_d       = 1'b1;
                tx_d       = 1'b0;
                bit_cnt_d  = 3'd0;
                baud_cnt_d = 16'd0;
`ifdef FIFO_UART_TX_PARITY_EN
                parity_d   = ^fifo.fifo_data;
`endif
            end

            S_START: begin
                if (baud_done) begin
                    baud_cnt_d = 16'd0;
                    state_d    = S_DATA;
                    tx_d       = shift_q[0];
                end else begin
                    baud_cnt_d = baud_cnt_q + 16'd1;
                end
            end

            S_DATA: begin
                if (baud_done) begin
                    baud_cnt_d = 16'd0;
                    if (bit_cnt_q == 3'd7) begin
`ifdef FIFO_UART_TX_PARITY_EN
                        state_d = S_PARITY;
                        tx_d    = parity_q;
`else
                        state_d = S_STOP;
                        tx_d    = 1'b1;
`endif
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        shift_d   = shift_q >> 1;
                        // Next bit is presented on the same edge as the shift.
                        tx_d      = shift_q[1];
                    end
                end else begin
                    baud_cnt_d = baud_cnt_q + 16'd1;
                end
            end

`ifdef FIFO_UART_TX_PARITY_EN
            S_PARITY: begin
                if (baud_done) begin
                    baud_cnt_d = 16'd0;
                    state_d    = S_STOP;
                    tx_d       = 1'b1;
                end else begin
                    baud_cnt_d = baud_cnt_q + 16'd1;
                end
            end
`endif

            S_STOP: begin
                tx_d = 1'b1;
                if (baud_done) begin
                    baud_cnt_d = 16'd0;
                    state_d    = S_IDLE;
                    busy_d     = 1'b0;
                end else begin
                    baud_cnt_d = baud_cnt_q + 16'd1;
                end
            end

            default: begin
                state_d    = S_IDLE;
                tx_d       = 1'b1;
                busy_d     = 1'b0;
                baud_cnt_d = 16'd0;
                bit_cnt_d  = 3'd0;
            end
        endcase
    end

    assign fifo.fifo_read_en = rd_q;
    assign tx                = tx_q;
    assign busy              = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_fifo_uart_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_fifo_uart_tx
// Purpose  : Self-checking bench for fifo_uart_tx with a behavioural FIFO
//            (one-cycle data lag, pop on falling edge of fifo_read_en) and a
//            scoreboard of queued bytes compared against decoded frames.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_fifo_uart_tx;

    localparam int N = 4;
`ifdef FIFO_UART_TX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif
    localparam int FRAME = NB * N;

    logic clk   = 1'b0;
    logic rst   = 1'b1;
    logic tx_en = 1'b0;
    logic tx;
    logic busy;

    fifo_uart_tx_if fif ();

    fifo_uart_tx #(.CLKS_PER_BIT(N)) dut (
        .sys_clock (clk),
        .reset     (rst),
        .tx_en     (tx_en),
        .fifo      (fif),
        .tx        (tx),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int         n_cmp = 0;
    int         n_bad = 0;
    int         cyc = 0;
    int         pop_cnt = 0;
    bit         wide_pulse = 1'b0;
    bit         busy_seen = 1'b0;
    bit         low_seen = 1'b0;
    logic       prev_rd = 1'b0;
    logic [7:0] pending = 8'h00;
    logic [7:0] fq[$];
    logic [7:0] exp_q[$];

    // FIFO model and line monitor, 1 ns after each rising edge.
    always @(posedge clk) begin
        #1;
        cyc++;
        if (prev_rd === 1'b1 && fif.fifo_read_en === 1'b0 && fq.size() > 0)
            void'(fq.pop_front());
        if (fif.fifo_read_en === 1'b1) pop_cnt++;
        if (fif.fifo_read_en === 1'b1 && prev_rd === 1'b1) wide_pulse = 1'b1;
        prev_rd        = fif.fifo_read_en;
        fif.fifo_data  = pending;
        pending        = (fq.size() > 0) ? fq[0] : 8'h00;
        fif.fifo_empty = (fq.size() == 0);
        if (busy === 1'b1) busy_seen = 1'b1;
        if (tx !== 1'b1)   low_seen  = 1'b1;
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic push(input logic [7:0] b);
        fq.push_back(b);
        exp_q.push_back(b);
    endtask

    // Bit 0 = start; unused trailing bits are 1.
    function automatic logic [10:0] frame_of(input logic [7:0] b);
        logic [10:0] f;
        f      = '1;
        f[0]   = 1'b0;
        f[8:1] = b;
`ifdef FIFO_UART_TX_PARITY_EN
        f[9]   = ^b;
`endif
        return f;
    endfunction

    // Captures one frame by mid-bit sampling. Returns at mid stop bit.
    task automatic rx_frame(input bit started, input int drop_at,
                            output logic [10:0] bits, output bit ok,
                            output int t_fall);
        int w;
        bits   = '1;
        ok     = 1'b1;
        t_fall = cyc;
        if (!started) begin
            w = 0;
            while (tx !== 1'b0 && w < 200) begin
                step(1);
                w++;
            end
            if (tx !== 1'b0) begin
                ok = 1'b0;
                return;
            end
        end
        t_fall = cyc;
        for (int c = 1; c <= (NB - 1) * N + N / 2; c++) begin
            step(1);
            if (c == drop_at) tx_en = 1'b0;
            if (c % N == N / 2) bits[c / N] = tx;
        end
    endtask

    task automatic test_reset;
        int p0;
        rst   = 1'b1;
        tx_en = 1'b0;
        step(3);
        n_cmp++; if (tx !== 1'b1) begin n_bad++; $display("FAIL reset_tx: got %b expected 1", tx); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_cmp++; if (fif.fifo_read_en !== 1'b0) begin n_bad++; $display("FAIL reset_rd: got %b expected 0", fif.fifo_read_en); end
        rst       = 1'b0;
        tx_en     = 1'b1;
        busy_seen = 1'b0;
        low_seen  = 1'b0;
        p0        = pop_cnt;
        step(5000);
        n_cmp++; if (pop_cnt - p0 != 0) begin n_bad++; $display("FAIL empty_pops: got %0d expected 0", pop_cnt - p0); end
        n_cmp++; if (busy_seen !== 1'b0) begin n_bad++; $display("FAIL empty_busy: got %b expected 0", busy_seen); end
        n_cmp++; if (low_seen !== 1'b0) begin n_bad++; $display("FAIL empty_txlow: got %b expected 0", low_seen); end
    endtask

    task automatic test_single;
        int               p0;
        int               w;
        logic [FRAME-1:0] obs;
        logic [FRAME-1:0] expv;
        logic [10:0]      f;
        logic [7:0]       d;
        logic [7:0]       e;
        logic             rd0, rd1, busy_a, busy_b;
        p0 = pop_cnt;
        push(8'hA5);
        w = 0;
        while (tx !== 1'b0 && w < 200) begin step(1); w++; end
        n_cmp++;
        if (tx !== 1'b0) begin
            n_bad++; $display("FAIL single_start: got tx=%b expected 0 within 200 cycles", tx);
            return;
        end
        obs    = '1;
        obs[0] = tx;
        rd0    = fif.fifo_read_en;
        rd1    = 1'b0; busy_a = 1'b0; busy_b = 1'b1;
        for (int c = 1; c <= FRAME; c++) begin
            step(1);
            if (c < FRAME)      obs[c] = tx;
            if (c == 1)         rd1 = fif.fifo_read_en;
            if (c == FRAME - 1) busy_a = busy;
            if (c == FRAME)     busy_b = busy;
        end
        f = frame_of(8'hA5);
        for (int c = 0; c < FRAME; c++) expv[c] = f[c / N];
        for (int i = 0; i < 8; i++) d[i] = obs[(i + 1) * N + N / 2];
        e = exp_q.pop_front();
        n_cmp++; if (obs !== expv) begin n_bad++; $display("FAIL single_wave: got %b expected %b", obs, expv); end
        n_cmp++; if (d !== e) begin n_bad++; $display("FAIL single_data: got %h expected %h", d, e); end
        n_cmp++; if (rd0 !== 1'b1) begin n_bad++; $display("FAIL single_rd_rise: got %b expected 1", rd0); end
        n_cmp++; if (rd1 !== 1'b0) begin n_bad++; $display("FAIL single_rd_fall: got %b expected 0", rd1); end
        n_cmp++; if (busy_a !== 1'b1) begin n_bad++; $display("FAIL single_busy_hold: got %b expected 1", busy_a); end
        n_cmp++; if (busy_b !== 1'b0) begin n_bad++; $display("FAIL single_busy_drop: got %b expected 0", busy_b); end
        n_cmp++; if (pop_cnt - p0 != 1) begin n_bad++; $display("FAIL single_pops: got %0d expected 1", pop_cnt - p0); end
        n_cmp++; if (wide_pulse !== 1'b0) begin n_bad++; $display("FAIL single_pulse_width: got wide=%b expected 0", wide_pulse); end
    endtask

    task automatic test_back_to_back;
        int          p0;
        int          tf;
        int          tprev;
        bit          ok;
        logic [10:0] bits;
        logic [7:0]  e;
        p0    = pop_cnt;
        tprev = 0;
        push(8'h00);
        push(8'hFF);
        push(8'h55);
        for (int k = 0; k < 3; k++) begin
            rx_frame(1'b0, -1, bits, ok, tf);
            n_cmp++;
            if (!ok) begin
                n_bad++; $display("FAIL b2b_frame%0d: got no start bit expected one within 200 cycles", k);
                break;
            end
            e = exp_q.pop_front();
            n_cmp++; if (bits !== frame_of(e)) begin n_bad++; $display("FAIL b2b_data%0d: got %b expected %b", k, bits, frame_of(e)); end
            if (k > 0) begin
                n_cmp++; if (tf - tprev != FRAME + 2) begin n_bad++; $display("FAIL b2b_spacing%0d: got %0d expected %0d", k, tf - tprev, FRAME + 2); end
            end
            tprev = tf;
        end
        step(60);
        n_cmp++; if (pop_cnt - p0 != 3) begin n_bad++; $display("FAIL b2b_pops: got %0d expected 3", pop_cnt - p0); end
        n_cmp++; if (fq.size() != 0) begin n_bad++; $display("FAIL b2b_fifo_left: got %0d expected 0", fq.size()); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL b2b_busy: got %b expected 0", busy); end
    endtask

    task automatic test_tx_en_drop;
        int          p0;
        int          tf;
        bit          ok;
        logic [10:0] bits;
        logic [7:0]  e;
        p0 = pop_cnt;
        push(8'h3C);
        push(8'h11);
        rx_frame(1'b0, 20, bits, ok, tf);
        n_cmp++;
        if (!ok) begin
            n_bad++; $display("FAIL drop_frame: got no start bit expected one within 200 cycles");
            tx_en = 1'b1;
            return;
        end
        e = exp_q.pop_front();
        n_cmp++; if (bits !== frame_of(e)) begin n_bad++; $display("FAIL drop_data: got %b expected %b", bits, frame_of(e)); end
        low_seen = 1'b0;
        step(60);
        n_cmp++; if (low_seen !== 1'b0) begin n_bad++; $display("FAIL drop_new_frame: got txlow=%b expected 0", low_seen); end
        n_cmp++; if (pop_cnt - p0 != 1) begin n_bad++; $display("FAIL drop_pops: got %0d expected 1", pop_cnt - p0); end
        n_cmp++; if (fq.size() != 1) begin n_bad++; $display("FAIL drop_fifo_left: got %0d expected 1", fq.size()); end
        tx_en = 1'b1;
        step(1);
        n_cmp++; if ({busy, fif.fifo_read_en, tx} !== 3'b101) begin n_bad++; $display("FAIL drop_wait: got busy/rd/tx=%b expected 101", {busy, fif.fifo_read_en, tx}); end
        step(1);
        n_cmp++; if ({fif.fifo_read_en, tx} !== 2'b10) begin n_bad++; $display("FAIL drop_pop: got rd/tx=%b expected 10", {fif.fifo_read_en, tx}); end
        rx_frame(1'b1, -1, bits, ok, tf);
        e = exp_q.pop_front();
        n_cmp++; if (bits !== frame_of(e)) begin n_bad++; $display("FAIL drop_resume_data: got %b expected %b", bits, frame_of(e)); end
        step(20);
        n_cmp++; if (fq.size() != 0) begin n_bad++; $display("FAIL drop_fifo_end: got %0d expected 0", fq.size()); end
    endtask

    task automatic test_reset_mid;
        int          w;
        int          tf;
        bit          ok;
        logic [10:0] bits;
        logic [7:0]  e;
        push(8'h96);
        w = 0;
        while (tx !== 1'b0 && w < 200) begin step(1); w++; end
        n_cmp++;
        if (tx !== 1'b0) begin
            n_bad++; $display("FAIL rmid_start: got tx=%b expected 0 within 200 cycles", tx);
            return;
        end
        step(4 * N + 1);   // inside data bit 3
        rst = 1'b1;
        step(1);
        n_cmp++; if ({tx, busy, fif.fifo_read_en} !== 3'b100) begin n_bad++; $display("FAIL rmid_reset: got tx/busy/rd=%b expected 100", {tx, busy, fif.fifo_read_en}); end
        rst = 1'b0;
        void'(exp_q.pop_front());    // popped byte is discarded by reset
        n_cmp++; if (fq.size() != 0) begin n_bad++; $display("FAIL rmid_fifo: got %0d expected 0", fq.size()); end
        step(5);
        push(8'hC3);
        rx_frame(1'b0, -1, bits, ok, tf);
        n_cmp++;
        if (!ok) begin
            n_bad++; $display("FAIL rmid_next_frame: got no start bit expected one within 200 cycles");
            return;
        end
        e = exp_q.pop_front();
        n_cmp++; if (bits !== frame_of(e)) begin n_bad++; $display("FAIL rmid_next_data: got %b expected %b", bits, frame_of(e)); end
        step(10);
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rmid_busy_end: got %b expected 0", busy); end
    endtask

`ifdef FIFO_UART_TX_PARITY_EN
    task automatic test_parity;
        int          tf;
        bit          ok;
        logic [10:0] bits;
        logic [7:0]  e;
        push(8'h07);
        rx_frame(1'b0, -1, bits, ok, tf);
        n_cmp++;
        if (!ok) begin
            n_bad++; $display("FAIL par_frame: got no start bit expected one within 200 cycles");
            return;
        end
        e = exp_q.pop_front();
        n_cmp++; if (bits !== frame_of(e)) begin n_bad++; $display("FAIL par_data: got %b expected %b", bits, frame_of(e)); end
        n_cmp++; if (bits[9] !== 1'b1) begin n_bad++; $display("FAIL par_bit: got %b expected 1", bits[9]); end
        step(1);
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL par_busy_hold: got %b expected 1", busy); end
        step(1);
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL par_busy_drop: got %b expected 0", busy); end
    endtask
`endif

    initial begin
        test_reset;
        test_single;
        test_back_to_back;
        test_tx_en_drop;
        test_reset_mid;
`ifdef FIFO_UART_TX_PARITY_EN
        test_parity;
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
